// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types and helpers for the MEM stage and its store buffer.
//   sb_entry_t      : one buffered store {addr, size, data}
//   XFER_B/H/W/D    : legal transfer sizes in bytes (1, 2, 4, 8)
//   size_legal()    : size is one of the legal transfer sizes
//   is_aligned()    : address is a multiple of the (legal) size
//   ranges_overlap(): two byte ranges [addr, addr+size) intersect
//   size_mask()     : byte-lane mask covering the low 'size' bytes
// Buffer entries are held at a fixed 64-bit address/data width. Transfers
// never exceed 8 bytes, so wider data buses carry zeros above bit 63.
// -----------------------------------------------------------------------------
package mem_pkg;

   localparam int SB_ADDR_W = 64;
   localparam int SB_DATA_W = 64;

   localparam logic [3:0] XFER_B = 4'd1;
   localparam logic [3:0] XFER_H = 4'd2;
   localparam logic [3:0] XFER_W = 4'd4;
   localparam logic [3:0] XFER_D = 4'd8;

   typedef struct packed {
      logic [SB_ADDR_W-1:0] addr;
      logic [3:0]           size;
      logic [SB_DATA_W-1:0] data;
   } sb_entry_t;

   function automatic logic size_legal(input logic [3:0] size);
      return (size == XFER_B) || (size == XFER_H) || (size == XFER_W) || (size == XFER_D);
   endfunction

   // Only meaningful for power-of-two sizes; callers check size_legal first.
   function automatic logic is_aligned(input logic [SB_ADDR_W-1:0] addr,
                                       input logic [3:0]           size);
      logic [SB_ADDR_W-1:0] low_mask;
      low_mask = {{(SB_ADDR_W-4){1'b0}}, size - 4'd1};
      return (addr & low_mask) == '0;
   endfunction

   // End addresses carry an extra bit so ranges at the top of the address
   // space do not wrap and produce a false miss.
   function automatic logic ranges_overlap(input logic [SB_ADDR_W-1:0] a_addr,
                                           input logic [3:0]           a_size,
                                           input logic [SB_ADDR_W-1:0] b_addr,
                                           input logic [3:0]           b_size);
      logic [SB_ADDR_W:0] a_end;
      logic [SB_ADDR_W:0] b_end;
      a_end = {1'b0, a_addr} + {{(SB_ADDR_W-3){1'b0}}, a_size};
      b_end = {1'b0, b_addr} + {{(SB_ADDR_W-3){1'b0}}, b_size};
      return ({1'b0, a_addr} < b_end) && ({1'b0, b_addr} < a_end);
   endfunction

   function automatic logic [SB_DATA_W-1:0] size_mask(input logic [3:0] size);
      logic [SB_DATA_W-1:0] m;
      m = '0;
      for (int k = 0; k < 8; k++) begin
         if (k < int'(size)) begin
            m[8*k +: 8] = 8'hFF;
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/mem_store_buffer.sv
// -----------------------------------------------------------------------------
// mem_store_buffer
// Circular in-order store FIFO with a parallel lookup against all live entries.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset (pointers/count only)
//   enq, enq_entry : push one store at the rising edge
//   deq            : pop the head at the rising edge (only when count > 0)
//   lookup_addr/size : byte range of the current load
//   count          : live entries, 0..SB_DEPTH
//   head_entry     : oldest entry, valid when count > 0
//   hit            : some live entry overlaps the lookup range
//   exact          : youngest overlapping entry has the same addr and size
//   fwd_data       : youngest overlapping entry's data masked to lookup size
// -----------------------------------------------------------------------------
module mem_store_buffer
   import mem_pkg::*;
#(
   parameter int SB_DEPTH = 4
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enq,
   input  sb_entry_t                     enq_entry,
   input  logic                          deq,
   input  logic [SB_ADDR_W-1:0]          lookup_addr,
   input  logic [3:0]                    lookup_size,
   output logic [$clog2(SB_DEPTH):0]     count,
   output sb_entry_t                     head_entry,
   output logic                          hit,
   output logic                          exact,
   output logic [SB_DATA_W-1:0]          fwd_data
);

   localparam int PTR_W = $clog2(SB_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   sb_entry_t        entries [SB_DEPTH];
   logic [PTR_W-1:0] head_ptr;
   logic [PTR_W-1:0] tail_ptr;

   // Pointers wrap naturally because SB_DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
      end else begin
         if (enq) begin
            tail_ptr <= tail_ptr + PTR_W'(1);
         end
         if (deq) begin
            head_ptr <= head_ptr + PTR_W'(1);
         end
         if (enq && !deq) begin
            count <= count + CNT_W'(1);
         end else if (deq && !enq) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   // Entry storage is not reset; the count alone decides what is live.
   always_ff @(posedge clk) begin
      if (enq) begin
         entries[tail_ptr] <= enq_entry;
      end
   end

   assign head_entry = entries[head_ptr];

   // Walk oldest to youngest so the last overlapping entry seen is the youngest.
   always_comb begin
      logic [PTR_W-1:0] idx;
      idx      = '0;
      hit      = 1'b0;
      exact    = 1'b0;
      fwd_data = '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         idx = head_ptr + PTR_W'(i);
         if ((CNT_W'(i) < count) &&
             ranges_overlap(entries[idx].addr, entries[idx].size, lookup_addr, lookup_size)) begin
            hit      = 1'b1;
            exact    = (entries[idx].addr == lookup_addr) && (entries[idx].size == lookup_size);
            fwd_data = entries[idx].data & size_mask(lookup_size);
         end
      end
   end

endmodule

// File: rtl/mem_stage_sb.sv
// -----------------------------------------------------------------------------
// mem_stage_sb
// Pipeline MEM stage with an in-order store buffer in front of a single-port
// data memory. Stores retire into the buffer; the buffer drains on any cycle
// where the memory port is not taken by a load. Loads read memory, forward
// from the buffer, or stall while overlapping stores drain.
// Configuration macro: MEM_STAGE_SB_FWD_EN
//   defined     : a load whose youngest overlapping entry matches exactly in
//                 address and size is forwarded from the buffer
//   not defined : any load overlapping a buffered entry stalls until it drains
// Ports:
//   clk, reset              : clock, asynchronous active-high reset
//   EXMEM_valid             : instruction in EX/MEM is live
//   EXMEM_ALUResult         : byte address
//   EXMEM_RegB_content      : store data (low bytes significant)
//   EXMEM_MemWrite          : store request
//   EXMEM_read_enable       : load request
//   EXMEM_xfer_size         : transfer size in bytes (1, 2, 4, 8)
//   MEM_datafromMem         : load data, zero-extended above the size
//   MEM_stall               : hold EX/MEM and earlier stages
//   MEM_err                 : illegal size or misaligned access (dropped)
//   dm_*                    : data-memory port; dm_read_data is combinational
// ADDR_W is limited to 64 bits by the buffer entry format.
// -----------------------------------------------------------------------------
module mem_stage_sb
   import mem_pkg::*;
#(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 64,
   parameter int SB_DEPTH = 4
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              EXMEM_valid,
   input  logic [ADDR_W-1:0] EXMEM_ALUResult,
   input  logic [DATA_W-1:0] EXMEM_RegB_content,
   input  logic              EXMEM_MemWrite,
   input  logic              EXMEM_read_enable,
   input  logic [3:0]        EXMEM_xfer_size,
   output logic [DATA_W-1:0] MEM_datafromMem,
   output logic              MEM_stall,
   output logic              MEM_err,
   output logic [ADDR_W-1:0] dm_address,
   output logic              dm_write_enable,
   output logic              dm_read_enable,
   output logic [DATA_W-1:0] dm_write_data,
   output logic [3:0]        dm_xfer_size,
   input  logic [DATA_W-1:0] dm_read_data
);

   localparam int CNT_W = $clog2(SB_DEPTH) + 1;

`ifdef MEM_STAGE_SB_FWD_EN
   localparam logic FWD_ENABLED = 1'b1;
`else
   localparam logic FWD_ENABLED = 1'b0;
`endif

   logic [SB_ADDR_W-1:0] req_addr;
   logic                 size_fits;
   logic                 access_req;
   logic                 access_legal;
   logic                 load_req;
   logic                 store_req;
   logic                 load_mem;
   logic                 load_fwd;
   logic                 drain;
   sb_entry_t            enq_entry;
   sb_entry_t            head_entry;
   logic [CNT_W-1:0]     sb_count;
   logic                 sb_hit;
   logic                 sb_exact;
   logic [SB_DATA_W-1:0] sb_fwd_data;

   assign req_addr  = SB_ADDR_W'(EXMEM_ALUResult);
   assign size_fits = (int'(EXMEM_xfer_size) * 8) <= DATA_W;

   assign access_req   = EXMEM_valid && (EXMEM_MemWrite || EXMEM_read_enable);
   assign access_legal = size_legal(EXMEM_xfer_size) && size_fits &&
                         is_aligned(req_addr, EXMEM_xfer_size);
   assign MEM_err      = access_req && !access_legal;
   assign load_req     = EXMEM_valid && EXMEM_read_enable && access_legal;
   assign store_req    = EXMEM_valid && EXMEM_MemWrite && access_legal;

   // Store data is masked on entry so forwarding and draining never expose
   // bytes above the transfer size.
   assign enq_entry = '{addr: req_addr,
                        size: EXMEM_xfer_size,
                        data: SB_DATA_W'(EXMEM_RegB_content) & size_mask(EXMEM_xfer_size)};

   // A load only takes the memory port when nothing buffered overlaps it;
   // every other cycle is free for draining the head.
   assign load_fwd  = load_req && sb_hit && sb_exact && FWD_ENABLED;
   assign MEM_stall = load_req && sb_hit && !(sb_exact && FWD_ENABLED);
   assign load_mem  = load_req && !sb_hit;
   assign drain     = !load_mem && (sb_count != '0);

   mem_store_buffer #(
      .SB_DEPTH (SB_DEPTH)
   ) u_store_buffer (
      .clk         (clk),
      .reset       (reset),
      .enq         (store_req),
      .enq_entry   (enq_entry),
      .deq         (drain),
      .lookup_addr (req_addr),
      .lookup_size (EXMEM_xfer_size),
      .count       (sb_count),
      .head_entry  (head_entry),
      .hit         (sb_hit),
      .exact       (sb_exact),
      .fwd_data    (sb_fwd_data)
   );

   always_comb begin
      dm_address      = '0;
      dm_read_enable  = 1'b0;
      dm_write_enable = 1'b0;
      dm_write_data   = '0;
      dm_xfer_size    = '0;
      if (load_mem) begin
         dm_address     = EXMEM_ALUResult;
         dm_read_enable = 1'b1;
         dm_xfer_size   = EXMEM_xfer_size;
      end else if (drain) begin
         dm_address      = ADDR_W'(head_entry.addr);
         dm_write_enable = 1'b1;
         dm_write_data   = DATA_W'(head_entry.data);
         dm_xfer_size    = head_entry.size;
      end
   end

   always_comb begin
      MEM_datafromMem = '0;
      if (load_mem) begin
         MEM_datafromMem = DATA_W'(SB_DATA_W'(dm_read_data) & size_mask(EXMEM_xfer_size));
      end else if (load_fwd) begin
         MEM_datafromMem = DATA_W'(sb_fwd_data);
      end
   end

endmodule
